// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote tally controller: session state
// encoding, scan-index sizing and one-hot/popcount checks.
package vote_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPEN = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // A single candidate index still needs one bit to be addressable.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int popcount(input logic [31:0] v);
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic logic is_onehot(input logic [31:0] v);
        return popcount(v) == 1;
    endfunction

endpackage

// File: rtl/vote_tally_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping, with a
// synchronous clear that shares priority with reset.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max
);

    assign at_max = &cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && !at_max)
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/vote_tally.sv
// Election controller: per-candidate saturating tallies, vote handshake,
// session FSM and a one-candidate-per-cycle winner scan with tie detection.
module vote_tally
    import vote_pkg::*;
#(
    parameter int NUM_CAND = 5,
    parameter int CNT_W    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      open_i,
    input  logic                      close_i,
    input  logic                      vote_valid,
    input  logic [NUM_CAND-1:0]       vote_sel,
    output logic                      vote_ack,
    output logic                      vote_rej,
    output logic [NUM_CAND*CNT_W-1:0] counts,
    output logic [1:0]                state,
    output logic                      result_valid,
    output logic [NUM_CAND-1:0]       win_mask,
    output logic [CNT_W-1:0]          win_count,
    output logic                      tie
);

    localparam int IDX_W = idx_width(NUM_CAND);

    state_t              st;
    logic [NUM_CAND-1:0] inc;
    logic [NUM_CAND-1:0] at_max;
    logic [CNT_W-1:0]    cnt_arr [NUM_CAND];
    logic                clr;
    logic                accept;

    logic [IDX_W-1:0]    idx;
    logic [CNT_W-1:0]    run_max;
    logic [NUM_CAND-1:0] run_mask;
    logic [CNT_W-1:0]    cur;
    logic [CNT_W-1:0]    nxt_max;
    logic [NUM_CAND-1:0] nxt_mask;
    logic [NUM_CAND-1:0] idx_bit;

    assign state = st;
    assign clr   = (st == ST_DONE) && open_i;

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_cand
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .inc    (inc[g]),
            .cnt    (cnt_arr[g]),
            .at_max (at_max[g])
        );
        assign counts[g*CNT_W +: CNT_W] = cnt_arr[g];
    end

    // Accept only a one-hot select whose target still has headroom.
    always_comb begin
        accept = vote_valid && (st == ST_OPEN) && is_onehot(32'(vote_sel))
                 && ((vote_sel & at_max) == '0);
        inc    = accept ? vote_sel : '0;
    end

    always_comb begin
        cur      = cnt_arr[idx];
        idx_bit  = NUM_CAND'(1) << idx;
        nxt_max  = run_max;
        nxt_mask = run_mask;
        if (idx == '0 || cur > run_max) begin
            nxt_max  = cur;
            nxt_mask = idx_bit;
        end else if (cur == run_max) begin
            nxt_mask = run_mask | idx_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st           <= ST_IDLE;
            idx          <= '0;
            run_max      <= '0;
            run_mask     <= '0;
            vote_ack     <= 1'b0;
            vote_rej     <= 1'b0;
            result_valid <= 1'b0;
            win_mask     <= '0;
            win_count    <= '0;
            tie          <= 1'b0;
        end else begin
            vote_ack <= accept;
            vote_rej <= vote_valid && !accept;
            case (st)
                ST_IDLE: if (open_i) st <= ST_OPEN;
                ST_OPEN: begin
                    if (close_i) begin
                        st       <= ST_SCAN;
                        idx      <= '0;
                        run_max  <= '0;
                        run_mask <= '0;
                    end
                end
                ST_SCAN: begin
                    run_max  <= nxt_max;
                    run_mask <= nxt_mask;
                    if (idx == IDX_W'(NUM_CAND - 1)) begin
                        st           <= ST_DONE;
                        result_valid <= 1'b1;
                        win_mask     <= nxt_mask;
                        win_count    <= nxt_max;
                        tie          <= popcount(32'(nxt_mask)) > 1;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (open_i) begin
                        st           <= ST_OPEN;
                        result_valid <= 1'b0;
                        win_mask     <= '0;
                        win_count    <= '0;
                        tie          <= 1'b0;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vote_tally.sv
// Scoreboard bench for vote_tally: handshake and election results are
// predicted at drive time and popped when the DUT responds.
module tb_vote_tally;
    import vote_pkg::*;

    localparam int NC = 5;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              open_i = 1'b0, close_i = 1'b0, vote_valid = 1'b0;
    logic [NC-1:0]     vote_sel = '0;
    logic              vote_ack, vote_rej, result_valid, tie;
    logic [NC*CW-1:0]  counts;
    logic [1:0]        state;
    logic [NC-1:0]     win_mask;
    logic [CW-1:0]     win_count;

    vote_tally #(.NUM_CAND(NC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .open_i(open_i), .close_i(close_i),
        .vote_valid(vote_valid), .vote_sel(vote_sel), .vote_ack(vote_ack),
        .vote_rej(vote_rej), .counts(counts), .state(state),
        .result_valid(result_valid), .win_mask(win_mask),
        .win_count(win_count), .tie(tie)
    );

    always #5 clk = ~clk;

    typedef struct { logic [NC-1:0] mask; logic [CW-1:0] cnt; logic tie; } res_t;
    typedef struct { logic ack; logic rej; } hs_t;

    res_t res_q[$];
    hs_t  hs_q[$];
    res_t cur_res;
    int   n_chk = 0, n_fail = 0;
    int   mcnt[NC];
    logic [1:0] mst = ST_IDLE;
    int   scan_n = 0;
    logic prev_rv = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res_t expect_res();
        res_t r;
        int mx = 0;
        for (int i = 0; i < NC; i++) if (mcnt[i] > mx) mx = mcnt[i];
        r.mask = '0;
        for (int i = 0; i < NC; i++) if (mcnt[i] == mx) r.mask[i] = 1'b1;
        r.cnt = CW'(mx);
        r.tie = $countones(r.mask) > 1;
        return r;
    endfunction

    task automatic cyc(input logic r, input logic vv, input logic [NC-1:0] sel,
                       input logic op, input logic cl);
        hs_t h;
        logic acc, sat;
        int k;
        @(negedge clk);
        rst = r; vote_valid = vv; vote_sel = sel; open_i = op; close_i = cl;
        if (r) begin
            h.ack = 1'b0; h.rej = 1'b0;
            mst = ST_IDLE;
            for (int i = 0; i < NC; i++) mcnt[i] = 0;
            res_q.delete();
        end else begin
            k = -1;
            for (int i = 0; i < NC; i++) if (sel[i]) k = i;
            sat = (k >= 0) && (mcnt[k] == (1 << CW) - 1);
            acc = vv && (mst == ST_OPEN) && ($countones(sel) == 1) && !sat;
            h.ack = acc;
            h.rej = vv && !acc;
            if (acc) mcnt[k]++;
            case (mst)
                ST_IDLE: if (op) mst = ST_OPEN;
                ST_OPEN: if (cl) begin
                    mst = ST_SCAN; scan_n = 0;
                    res_q.push_back(expect_res());
                end
                ST_SCAN: begin
                    scan_n++;
                    if (scan_n == NC) mst = ST_DONE;
                end
                default: if (op) begin
                    for (int i = 0; i < NC; i++) mcnt[i] = 0;
                    mst = ST_OPEN;
                end
            endcase
        end
        hs_q.push_back(h);
        @(posedge clk);
        #1;
        rst = 1'b0; vote_valid = 1'b0; vote_sel = '0; open_i = 1'b0; close_i = 1'b0;
        h = hs_q.pop_front();
        chk("vote_ack", vote_ack, h.ack);
        chk("vote_rej", vote_rej, h.rej);
        chk("state", state, mst);
        for (int i = 0; i < NC; i++) chk("count", counts[i*CW +: CW], mcnt[i]);
        chk("result_valid", result_valid, mst == ST_DONE);
        if (result_valid && !prev_rv) begin
            if (res_q.size() == 0) chk("result_pending", 0, 1);
            else cur_res = res_q.pop_front();
        end
        if (mst == ST_DONE) begin
            chk("win_mask", win_mask, cur_res.mask);
            chk("win_count", win_count, cur_res.cnt);
            chk("tie", tie, cur_res.tie);
        end else begin
            chk("win_mask_clr", win_mask, 0);
            chk("win_count_clr", win_count, 0);
            chk("tie_clr", tie, 0);
        end
        prev_rv = result_valid;
    endtask

    // Call right after the close cycle; that cycle counts as the first.
    task automatic wait_result();
        int n = 1;
        while (!result_valid && n < 20) begin
            cyc(0, 0, '0, 0, 0);
            n++;
        end
        chk("latency", n, NC + 1);
    endtask

    initial begin
        cyc(1, 0, '0, 0, 0);
        cyc(1, 0, '0, 0, 0);
        cyc(0, 1, 5'b00001, 0, 0);
        cyc(0, 0, '0, 1, 1);

        repeat (3) cyc(0, 1, 5'b00001, 0, 0);
        cyc(0, 1, 5'b00010, 0, 0);
        repeat (2) cyc(0, 1, 5'b00100, 0, 0);
        cyc(0, 0, '0, 0, 1);
        wait_result();
        cyc(0, 1, 5'b00001, 0, 0);
        cyc(0, 0, '0, 0, 1);
        cyc(0, 0, '0, 1, 0);

        cyc(0, 1, 5'b00011, 0, 0);
        cyc(0, 1, 5'b00000, 0, 0);

        repeat (2) cyc(0, 1, 5'b00010, 0, 0);
        cyc(0, 1, 5'b01000, 0, 0);
        cyc(0, 1, 5'b01000, 0, 1);
        wait_result();

        cyc(0, 0, '0, 1, 0);
        repeat (4) cyc(0, 1, 5'b10000, 0, 0);
        cyc(0, 0, '0, 1, 1);
        wait_result();

        cyc(0, 0, '0, 1, 1);
        cyc(0, 0, '0, 0, 1);
        wait_result();

        cyc(0, 0, '0, 1, 0);
        cyc(0, 1, 5'b00001, 0, 0);
        cyc(0, 0, '0, 0, 1);
        cyc(0, 0, '0, 1, 0);
        cyc(0, 1, 5'b00100, 0, 0);
        cyc(1, 0, '0, 0, 0);
        repeat (8) cyc(0, 0, '0, 0, 0);

        chk("result_queue_empty", res_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/vote_tally.md
Name: vote_tally

Overview:
- Parametrised election controller: N candidate counters, vote-acceptance handshake, election session state machine, and sequential winner scan with tie detection.
- Sits between the ballot front-end (debounced vote strobes) and the result display/logging logic.
- Successor to the fixed five-candidate machine. Adds:
  - configurable candidate count and counter width;
  - one-hot vote validation;
  - saturation;
  - open/close sessions;
  - registered winner result with a valid flag.

Parameters:
NUM_CAND, 5, number of candidates (2..32)
CNT_W, 32, width of each vote counter and of win_count (>=2)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
open_i  input  1  start new session (pulse)
close_i  input  1  end session and start winner scan (pulse)
vote_valid  input  1  vote strobe, one cycle per ballot
vote_sel  input  NUM_CAND  one-hot candidate select, sampled with vote_valid
vote_ack  output  1  registered pulse: previous-cycle vote counted
vote_rej  output  1  registered pulse: previous-cycle vote refused
counts  output  NUM_CAND*CNT_W  flattened live counters, candidate i at [i*CNT_W +: CNT_W]
state  output  2  IDLE=0, OPEN=1, SCAN=2, DONE=3
result_valid  output  1  high while state==DONE
win_mask  output  NUM_CAND  bit i set if candidate i holds the maximum count
win_count  output  CNT_W  maximum count
tie  output  1  more than one bit set in win_mask

Behaviour:
- Reset (rst=1 at clock edge) overrides everything:
  - state=IDLE; all counts=0; vote_ack=vote_rej=0; result_valid=0; win_mask=0; win_count=0; tie=0;
  - scan index=0.
- IDLE: open_i -> OPEN next cycle. Counts are already 0. A vote_valid in IDLE gives vote_rej=1 the next cycle.
- OPEN: a vote is accepted when vote_valid=1, vote_sel has exactly one bit set, and the selected counter is below 2^CNT_W-1.
  - Accepted: counter increments by 1 at this edge; vote_ack=1 the next cycle.
  - Any other vote_valid (zero or multiple bits, or target saturated): no counter changes; vote_rej=1 the next cycle.
  - vote_ack and vote_rej are never high together. Both are 0 when vote_valid was 0.
- OPEN + close_i -> SCAN.
  - A vote arriving in the same cycle as close_i is still evaluated and counted.
  - open_i in OPEN is ignored.
- SCAN walks one candidate per cycle, index 0..NUM_CAND-1, holding a running max and mask:
  - count > max: max=count, mask=one-hot(index);
  - count == max: set mask bit;
  - initial max=0, mask=0 before index 0 is compared, with candidate 0 always loading.
  - Exactly NUM_CAND cycles in SCAN, then DONE.
  - win_mask, win_count and tie are registered on the DONE transition. result_valid rises on the first DONE cycle.
  - Latency from the close_i edge to result_valid=1 is NUM_CAND+1 cycles.
- In SCAN and DONE:
  - votes are rejected (vote_rej pulses);
  - close_i is ignored;
  - open_i in SCAN is ignored.
- DONE:
  - results and counts are held stable;
  - open_i clears all counts, win_mask, win_count, tie and result_valid at that edge -> OPEN.
- All-zero election: every candidate ties at 0, so win_mask is all ones, win_count=0, tie=1.
- Counter arithmetic:
  - unsigned, no wrap;
  - a saturated counter stays at 2^CNT_W-1, and further votes for it are rejected.
- rst mid-SCAN or mid-OPEN: discard all state and return to IDLE on that edge. No partial result is ever flagged valid.
- open_i and close_i asserted together: in IDLE/DONE only open_i acts; in OPEN only close_i acts.

Decomposition:
- Package vote_pkg:
  - state encoding localparams (ST_IDLE, ST_OPEN, ST_SCAN, ST_DONE);
  - a constant function for the scan-index width, $clog2(NUM_CAND) with minimum 1;
  - a popcount/one-hot-check function.
- Sub-module sat_counter: CNT_W-bit saturating counter with sync clear, increment enable, and an at_max flag. Instantiated NUM_CAND times via generate.
- Top level holds the FSM, the vote-validation logic, the scan datapath and the output registers.

Test Plan:
- Reset/idle: rst for 2 cycles, then vote_valid with vote_sel=00001 in IDLE -> vote_rej=1 next cycle, counts all 0, state=0.
- Basic tally: NUM_CAND=5. Open; votes A×3, B×1, C×2; close -> after 6 cycles result_valid=1, win_mask=00001, win_count=3, tie=0.
- Invalid select: in OPEN, vote_sel=00011, then 00000 -> two vote_rej pulses, no count change, no vote_ack.
- Tie plus close collision: votes B×2 and D×1, then a D vote in the same cycle as close_i -> D counted, win_mask=01010, win_count=2, tie=1.
- Saturation: CNT_W=2. Four votes for E -> first three acked with count=3, fourth rejected; count stays 3.
- Reset mid-scan and restart: assert rst during SCAN -> IDLE, counts 0, result_valid never rises. Separately, open_i in DONE -> counts and result cleared, state=OPEN next cycle. Empty close then gives win_mask=11111, win_count=0, tie=1.
